// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and defaults for the register scoreboard and forwarding selector.
// Register addresses, the x1..x31 pending vector, and the "register file" select code.
package hazard_scoreboard_pkg;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:1] sb_vec_t;

    localparam int FWD_SEL_REG        = 0;
    localparam int HZ_NUM_FWD_DEF     = 2;
    localparam int HZ_MAX_PENDING_DEF = 4;

    // x0 is hard-wired to zero, so it can never be pending.
    function automatic logic sb_is_pending(input sb_vec_t vec, input reg_addr_t addr);
        logic [31:0] full_vec;
        full_vec = {vec, 1'b0};
        return full_vec[addr];
    endfunction

    function automatic sb_vec_t sb_onehot(input reg_addr_t addr);
        logic [31:0] mask;
        mask = 32'd1 << addr;
        return mask[31:1];
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode/Execute/Writeback hazard signals between the pipeline (master) and the scoreboard (slave).
// Suffixes are from the scoreboard's point of view: _i into it, _o out of it.
interface hazard_scoreboard_if
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_FWD = HZ_NUM_FWD_DEF,
    localparam int SEL_W  = $clog2(NUM_FWD + 1)
);

    logic                   valid_d_i;
    reg_addr_t              rs1_addr_d_i;
    reg_addr_t              rs2_addr_d_i;
    reg_addr_t              rd_addr_d_i;
    logic                   rs1_used_d_i;
    logic                   rs2_used_d_i;
    logic                   rd_wr_d_i;
    logic                   long_op_d_i;
    reg_addr_t              rs1_addr_e_i;
    reg_addr_t              rs2_addr_e_i;
    logic [NUM_FWD-1:0]     fwd_valid_i;
    logic [5*NUM_FWD-1:0]   fwd_rd_addr_i;
    logic                   wb_valid_i;
    logic                   wb_long_i;
    reg_addr_t              wb_rd_addr_i;
    logic                   pc_redirect_e_i;
    logic                   exec_stall_req_i;
    logic                   i_arvalid_i;
    logic                   i_arready_i;
    logic                   d_mem_req_i;
    logic                   d_mem_ready_i;

    logic                   stall_f_o;
    logic                   stall_d_o;
    logic                   stall_e_o;
    logic                   stall_m_o;
    logic                   stall_w_o;
    logic                   flush_f_o;
    logic                   flush_d_o;
    logic                   flush_e_o;
    logic [SEL_W-1:0]       forward_a_sel_o;
    logic [SEL_W-1:0]       forward_b_sel_o;
    logic                   sb_err_o;
    logic                   stall_timeout_o;

    modport master (
        output valid_d_i, rs1_addr_d_i, rs2_addr_d_i, rd_addr_d_i,
               rs1_used_d_i, rs2_used_d_i, rd_wr_d_i, long_op_d_i,
               rs1_addr_e_i, rs2_addr_e_i, fwd_valid_i, fwd_rd_addr_i,
               wb_valid_i, wb_long_i, wb_rd_addr_i,
               pc_redirect_e_i, exec_stall_req_i, i_arvalid_i, i_arready_i,
               d_mem_req_i, d_mem_ready_i,
        input  stall_f_o, stall_d_o, stall_e_o, stall_m_o, stall_w_o,
               flush_f_o, flush_d_o, flush_e_o,
               forward_a_sel_o, forward_b_sel_o, sb_err_o, stall_timeout_o
    );

    modport slave (
        input  valid_d_i, rs1_addr_d_i, rs2_addr_d_i, rd_addr_d_i,
               rs1_used_d_i, rs2_used_d_i, rd_wr_d_i, long_op_d_i,
               rs1_addr_e_i, rs2_addr_e_i, fwd_valid_i, fwd_rd_addr_i,
               wb_valid_i, wb_long_i, wb_rd_addr_i,
               pc_redirect_e_i, exec_stall_req_i, i_arvalid_i, i_arready_i,
               d_mem_req_i, d_mem_ready_i,
        output stall_f_o, stall_d_o, stall_e_o, stall_m_o, stall_w_o,
               flush_f_o, flush_d_o, flush_e_o,
               forward_a_sel_o, forward_b_sel_o, sb_err_o, stall_timeout_o
    );

endinterface

// File: rtl/hazard_scoreboard_fwd_sel.sv
// Youngest-first forwarding matcher for one Execute operand; purely combinational, no backpressure.
// Output k+1 selects stage k, 0 selects the register file.
module hazard_fwd_sel
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_FWD = HZ_NUM_FWD_DEF,
    localparam int SEL_W  = $clog2(NUM_FWD + 1)
) (
    input  logic [NUM_FWD-1:0]   fwd_valid_i,
    input  logic [5*NUM_FWD-1:0] fwd_rd_addr_i,
    input  reg_addr_t            rs_addr_i,
    output logic [SEL_W-1:0]     sel_o
);

    // Walk oldest to youngest so the youngest match is the last one written.
    always_comb begin
        sel_o = SEL_W'(FWD_SEL_REG);
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (fwd_valid_i[k] &&
                fwd_rd_addr_i[5*k +: 5] == rs_addr_i &&
                fwd_rd_addr_i[5*k +: 5] != 5'd0) begin
                sel_o = SEL_W'(k + 1);
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Register scoreboard for long-latency writes plus pipeline stall/flush/forward control; outputs combinational,
// state updates on the next edge; Decode is held while hazards exist. Optional watchdog: HAZARD_SB_WATCHDOG_EN.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_FWD       = HZ_NUM_FWD_DEF,
    parameter int MAX_PENDING   = HZ_MAX_PENDING_DEF,
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    hazard_scoreboard_if.slave   hz
);

    localparam int CNT_W = $clog2(MAX_PENDING + 1);

    sb_vec_t          pending_q, pending_d;
    logic [CNT_W-1:0] pend_cnt_q, pend_cnt_d;
    logic             sb_err_q, sb_err_d;

    logic raw_hz, waw_hz, full_hz, sb_hazard;
    logic issue, retire, retire_hit;
    logic stall_m, stall_e, stall_d, stall_f;

    always_comb begin
        raw_hz = (hz.rs1_used_d_i && sb_is_pending(pending_q, hz.rs1_addr_d_i)) ||
                 (hz.rs2_used_d_i && sb_is_pending(pending_q, hz.rs2_addr_d_i));
        waw_hz = hz.rd_wr_d_i && sb_is_pending(pending_q, hz.rd_addr_d_i);
        full_hz = hz.long_op_d_i && (pend_cnt_q == CNT_W'(MAX_PENDING));
        sb_hazard = hz.valid_d_i && (raw_hz || waw_hz || full_hz);
    end

    // A redirect squashes Decode, so its hazard must neither stall nor bubble.
    assign stall_m = hz.d_mem_req_i && !hz.d_mem_ready_i;
    assign stall_e = stall_m || hz.exec_stall_req_i;
    assign stall_d = stall_e || (sb_hazard && !hz.pc_redirect_e_i);
    assign stall_f = stall_d || (hz.i_arvalid_i && !hz.i_arready_i);

    assign hz.stall_w_o = 1'b0;
    assign hz.stall_m_o = stall_m;
    assign hz.stall_e_o = stall_e;
    assign hz.stall_d_o = stall_d;
    assign hz.stall_f_o = stall_f;
    assign hz.flush_f_o = hz.pc_redirect_e_i;
    assign hz.flush_d_o = hz.pc_redirect_e_i;
    assign hz.flush_e_o = sb_hazard && !stall_e && !hz.pc_redirect_e_i;
    assign hz.sb_err_o  = sb_err_q;

    assign issue = hz.valid_d_i && !stall_d && !hz.pc_redirect_e_i &&
                   hz.long_op_d_i && hz.rd_wr_d_i && (hz.rd_addr_d_i != 5'd0);
    assign retire     = hz.wb_valid_i && hz.wb_long_i && (hz.wb_rd_addr_i != 5'd0);
    assign retire_hit = retire && sb_is_pending(pending_q, hz.wb_rd_addr_i);

    always_comb begin
        pending_d = pending_q;
        if (retire) begin
            pending_d = pending_d & ~sb_onehot(hz.wb_rd_addr_i);
        end
        if (issue) begin
            pending_d = pending_d | sb_onehot(hz.rd_addr_d_i);
        end

        pend_cnt_d = pend_cnt_q;
        unique case ({issue, retire_hit})
            2'b10:   pend_cnt_d = pend_cnt_q + CNT_W'(1);
            2'b01:   pend_cnt_d = pend_cnt_q - CNT_W'(1);
            default: pend_cnt_d = pend_cnt_q;
        endcase

        // Retiring a register that was never issued points at a pipeline bug upstream.
        sb_err_d = sb_err_q || (retire && !retire_hit);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q  <= '0;
            pend_cnt_q <= '0;
            sb_err_q   <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            pend_cnt_q <= pend_cnt_d;
            sb_err_q   <= sb_err_d;
        end
    end

`ifdef HAZARD_SB_WATCHDOG_EN
    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic        timeout_q, timeout_d;

    always_comb begin
        wd_cnt_d  = '0;
        if (stall_d) begin
            wd_cnt_d = (wd_cnt_q == 16'hFFFF) ? wd_cnt_q : wd_cnt_q + 16'd1;
        end
        timeout_d = timeout_q || (wd_cnt_d == 16'(STALL_TIMEOUT));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign hz.stall_timeout_o = timeout_q;
`else
    assign hz.stall_timeout_o = 1'b0;
`endif

    hazard_fwd_sel #(.NUM_FWD(NUM_FWD)) u_fwd_a (
        .fwd_valid_i   (hz.fwd_valid_i),
        .fwd_rd_addr_i (hz.fwd_rd_addr_i),
        .rs_addr_i     (hz.rs1_addr_e_i),
        .sel_o         (hz.forward_a_sel_o)
    );

    hazard_fwd_sel #(.NUM_FWD(NUM_FWD)) u_fwd_b (
        .fwd_valid_i   (hz.fwd_valid_i),
        .fwd_rd_addr_i (hz.fwd_rd_addr_i),
        .rs_addr_i     (hz.rs2_addr_e_i),
        .sel_o         (hz.forward_b_sel_o)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: combinational vector table, then scoreboard sequences (load-use, full, redirect, error, reset, watchdog).
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk_i = ~clk_i;

    hazard_scoreboard_if #(.NUM_FWD(2)) hz ();

    hazard_scoreboard #(
        .NUM_FWD       (2),
        .MAX_PENDING   (4),
        .STALL_TIMEOUT (16)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .hz    (hz)
    );

    typedef struct {
        logic [1:0] fv;
        logic [9:0] frd;
        logic [4:0] rs1_e;
        logic [4:0] rs2_e;
        logic       dreq, drdy, xst, arv, ardy, redir;
        logic [1:0] exp_a;
        logic [1:0] exp_b;
        logic [4:0] exp_stall;   // {f,d,e,m,w}
        logic [2:0] exp_flush;   // {f,d,e}
    } vec_t;

    vec_t vt [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_dec(input logic v, input reg_addr_t rs1, input logic u1,
                           input reg_addr_t rs2, input logic u2,
                           input reg_addr_t rd, input logic wr, input logic lng);
        hz.valid_d_i    = v;
        hz.rs1_addr_d_i = rs1;
        hz.rs1_used_d_i = u1;
        hz.rs2_addr_d_i = rs2;
        hz.rs2_used_d_i = u2;
        hz.rd_addr_d_i  = rd;
        hz.rd_wr_d_i    = wr;
        hz.long_op_d_i  = lng;
    endtask

    task automatic set_wb(input logic v, input reg_addr_t rd);
        hz.wb_valid_i   = v;
        hz.wb_long_i    = v;
        hz.wb_rd_addr_i = rd;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic wd_exp;

        set_dec(0, 0, 0, 0, 0, 0, 0, 0);
        set_wb(0, 0);
        hz.rs1_addr_e_i = 0; hz.rs2_addr_e_i = 0;
        hz.fwd_valid_i = 0; hz.fwd_rd_addr_i = 0;
        hz.pc_redirect_e_i = 0; hz.exec_stall_req_i = 0;
        hz.i_arvalid_i = 0; hz.i_arready_i = 0;
        hz.d_mem_req_i = 0; hz.d_mem_ready_i = 0;

        //        fv     frd               rs1 rs2 dreq drdy xst arv ardy red  a  b  stall     flush
        vt[0]  = '{2'b00, 10'd0,            0,  0,  0,   0,   0,  0,  0,   0,  0, 0, 5'b00000, 3'b000};
        vt[1]  = '{2'b11, {5'd9, 5'd9},     9,  0,  0,   0,   0,  0,  0,   0,  1, 0, 5'b00000, 3'b000};
        vt[2]  = '{2'b10, {5'd9, 5'd9},     9,  0,  0,   0,   0,  0,  0,   0,  2, 0, 5'b00000, 3'b000};
        vt[3]  = '{2'b11, {5'd0, 5'd0},     0,  0,  0,   0,   0,  0,  0,   0,  0, 0, 5'b00000, 3'b000};
        vt[4]  = '{2'b11, {5'd4, 5'd3},     4,  3,  0,   0,   0,  0,  0,   0,  2, 1, 5'b00000, 3'b000};
        vt[5]  = '{2'b01, {5'd7, 5'd7},     7,  7,  0,   0,   0,  0,  0,   0,  1, 1, 5'b00000, 3'b000};
        vt[6]  = '{2'b00, 10'd0,            0,  0,  1,   0,   0,  0,  0,   0,  0, 0, 5'b11110, 3'b000};
        vt[7]  = '{2'b00, 10'd0,            0,  0,  1,   1,   0,  0,  0,   0,  0, 0, 5'b00000, 3'b000};
        vt[8]  = '{2'b00, 10'd0,            0,  0,  0,   0,   1,  0,  0,   0,  0, 0, 5'b11100, 3'b000};
        vt[9]  = '{2'b00, 10'd0,            0,  0,  0,   0,   0,  1,  0,   0,  0, 0, 5'b10000, 3'b000};
        vt[10] = '{2'b00, 10'd0,            0,  0,  0,   0,   0,  0,  0,   1,  0, 0, 5'b00000, 3'b110};

        // Reset state, sampled while reset is held.
        #12;
        chk("rst_sb_err", 32'(hz.sb_err_o), 0);
        chk("rst_timeout", 32'(hz.stall_timeout_o), 0);
        chk("rst_stall_d", 32'(hz.stall_d_o), 0);
        tick();
        rst_i = 1'b0;
        tick();

        foreach (vt[i]) begin
            hz.fwd_valid_i      = vt[i].fv;
            hz.fwd_rd_addr_i    = vt[i].frd;
            hz.rs1_addr_e_i     = vt[i].rs1_e;
            hz.rs2_addr_e_i     = vt[i].rs2_e;
            hz.d_mem_req_i      = vt[i].dreq;
            hz.d_mem_ready_i    = vt[i].drdy;
            hz.exec_stall_req_i = vt[i].xst;
            hz.i_arvalid_i      = vt[i].arv;
            hz.i_arready_i      = vt[i].ardy;
            hz.pc_redirect_e_i  = vt[i].redir;
            #2;
            chk($sformatf("vec%0d_fwd", i),
                32'({hz.forward_a_sel_o, hz.forward_b_sel_o}), 32'({vt[i].exp_a, vt[i].exp_b}));
            chk($sformatf("vec%0d_stall", i),
                32'({hz.stall_f_o, hz.stall_d_o, hz.stall_e_o, hz.stall_m_o, hz.stall_w_o}),
                32'(vt[i].exp_stall));
            chk($sformatf("vec%0d_flush", i),
                32'({hz.flush_f_o, hz.flush_d_o, hz.flush_e_o}), 32'(vt[i].exp_flush));
        end
        hz.fwd_valid_i = 0; hz.fwd_rd_addr_i = 0;
        hz.rs1_addr_e_i = 0; hz.rs2_addr_e_i = 0;
        hz.d_mem_req_i = 0; hz.d_mem_ready_i = 0; hz.exec_stall_req_i = 0;
        hz.i_arvalid_i = 0; hz.i_arready_i = 0; hz.pc_redirect_e_i = 0;
        tick();

        // Load x5, then ADD x6,x5,x1 waits until the cycle after x5 retires.
        set_dec(1, 2, 1, 0, 0, 5, 1, 1);
        #1 chk("lw_issue_stall", 32'(hz.stall_d_o), 0);
        tick();
        set_dec(1, 5, 1, 1, 1, 6, 1, 0);
        #1 chk("lu_stall_c1", 32'(hz.stall_d_o), 1);
        chk("lu_bubble_c1", 32'(hz.flush_e_o), 1);
        tick();
        chk("lu_stall_c2", 32'(hz.stall_d_o), 1);
        set_wb(1, 5);
        #1 chk("lu_stall_wb", 32'(hz.stall_d_o), 1);
        tick();
        set_wb(0, 0);
        #1 chk("lu_release", 32'(hz.stall_d_o), 0);
        chk("lu_no_bubble", 32'(hz.flush_e_o), 0);
        tick();
        set_dec(0, 0, 0, 0, 0, 0, 0, 0);

        // Fill all four slots with DIVs to x1..x4; a fifth long op stalls on capacity alone.
        for (int k = 1; k <= 4; k++) begin
            set_dec(1, 0, 0, 0, 0, 5'(k), 1, 1);
            #1 chk($sformatf("div%0d_issue", k), 32'(hz.stall_d_o), 0);
            tick();
        end
        set_dec(1, 11, 1, 12, 1, 10, 1, 0);
        #1 chk("full_short_op_ok", 32'(hz.stall_d_o), 0);
        set_dec(1, 0, 0, 0, 0, 7, 1, 1);
        #1 chk("full_stall", 32'(hz.stall_d_o), 1);
        chk("full_bubble", 32'(hz.flush_e_o), 1);
        tick();
        chk("full_stall_hold", 32'(hz.stall_d_o), 1);
        set_wb(1, 2);
        #1 chk("full_stall_wb", 32'(hz.stall_d_o), 1);
        tick();
        set_wb(0, 0);
        #1 chk("full_release", 32'(hz.stall_d_o), 0);
        tick();
        set_dec(1, 7, 1, 0, 0, 0, 0, 0);
        #1 chk("x7_pending", 32'(hz.stall_d_o), 1);
        set_dec(1, 2, 1, 0, 0, 0, 0, 0);
        #1 chk("x2_retired", 32'(hz.stall_d_o), 0);
        set_dec(0, 0, 0, 0, 0, 0, 0, 0);
        foreach (vt[i]) begin
            if (i < 4) begin
                set_wb(1, (i == 0) ? 5'd1 : (i == 1) ? 5'd3 : (i == 2) ? 5'd4 : 5'd7);
                tick();
            end
        end
        set_wb(0, 0);
        #1 chk("drain_no_err", 32'(hz.sb_err_o), 0);

        // Redirect overrides a RAW on x3 and blocks the squashed long op from issuing.
        set_dec(1, 0, 0, 0, 0, 3, 1, 1);
        #1 chk("x3_issue", 32'(hz.stall_d_o), 0);
        tick();
        set_dec(1, 3, 1, 0, 0, 9, 1, 1);
        hz.pc_redirect_e_i = 1;
        #1 chk("redir_flush_d", 32'(hz.flush_d_o), 1);
        chk("redir_flush_f", 32'(hz.flush_f_o), 1);
        chk("redir_stall_d", 32'(hz.stall_d_o), 0);
        chk("redir_flush_e", 32'(hz.flush_e_o), 0);
        tick();
        hz.pc_redirect_e_i = 0;
        set_dec(1, 9, 1, 0, 0, 0, 0, 0);
        #1 chk("redir_x9_not_set", 32'(hz.stall_d_o), 0);
        set_dec(1, 9, 1, 3, 1, 0, 0, 0);
        #1 chk("redir_x3_kept", 32'(hz.stall_d_o), 1);
        set_dec(0, 0, 0, 0, 0, 0, 0, 0);
        set_wb(1, 3);
        tick();
        set_wb(0, 0);

        // Retire of a non-pending x8 sets the sticky error without disturbing the count.
        set_wb(1, 8);
        #1 chk("err_before", 32'(hz.sb_err_o), 0);
        tick();
        set_wb(0, 0);
        #1 chk("err_set", 32'(hz.sb_err_o), 1);
        tick();
        chk("err_sticky", 32'(hz.sb_err_o), 1);
        for (int k = 12; k <= 15; k++) begin
            set_dec(1, 0, 0, 0, 0, 5'(k), 1, 1);
            #1 chk($sformatf("cnt_issue_x%0d", k), 32'(hz.stall_d_o), 0);
            tick();
        end
        set_dec(1, 0, 0, 0, 0, 16, 1, 1);
        #1 chk("cnt_full_after_err", 32'(hz.stall_d_o), 1);
        set_dec(1, 12, 1, 0, 0, 0, 0, 0);
        #1 chk("raw_x12", 32'(hz.stall_d_o), 1);

        // Asynchronous reset mid-cycle clears pending state and the error flag immediately.
        rst_i = 1'b1;
        #1 chk("arst_stall_d", 32'(hz.stall_d_o), 0);
        chk("arst_sb_err", 32'(hz.sb_err_o), 0);
        tick();
        rst_i = 1'b0;
        set_dec(0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Hold Execute stalled for 20 cycles.
        hz.exec_stall_req_i = 1;
        for (int i = 1; i <= 20; i++) begin
            tick();
`ifdef HAZARD_SB_WATCHDOG_EN
            wd_exp = (i >= 16);
`else
            wd_exp = 1'b0;
`endif
            chk($sformatf("wd_cycle%0d", i), 32'(hz.stall_timeout_o), 32'(wd_exp));
        end
        hz.exec_stall_req_i = 0;
        tick();
        tick();
`ifdef HAZARD_SB_WATCHDOG_EN
        wd_exp = 1'b1;
`else
        wd_exp = 1'b0;
`endif
        chk("wd_after_release", 32'(hz.stall_timeout_o), 32'(wd_exp));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
